freq_gate_ctrl: RTL and testbench

Measurement sequencer for a cascade of BCD decade counters in the frequency-meter datapath. Each cycle it clears the counter chain, opens a count-enable gate of exactly GATE_CYCLES clk cycles, waits one settle cycle, then latches the cascade's BCD digits into a display result register. It supports single-shot and continuous operation, an abort input, and a top-digit overflow capture.

---
 rtl/freq_gate_pkg.sv | 26 ++
 rtl/freq_gate_ctrl_timer.sv | 27 ++
 rtl/freq_gate_ctrl.sv | 111 +++++++++++
 tb/tb_freq_gate_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gate_pkg.sv
// Shared types and constants for the frequency-meter gate sequencer.
package freq_gate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_SETTLE,
    ST_LATCH
  } state_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [3:0]  BCD_NINE   = 4'h9;
  localparam int unsigned MAX_DIGITS = 16;

  // All-9 BCD pattern for the low n_digits nibbles; callers truncate to their width.
  function automatic logic [DIGIT_W*MAX_DIGITS-1:0] all_nines(input int unsigned n_digits);
    logic [DIGIT_W*MAX_DIGITS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < n_digits) v[i*DIGIT_W +: DIGIT_W] = BCD_NINE;
    end
    return v;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_timer.sv
// Loadable down-counter; done flags the final cycle of a timed state.
module gate_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate sequencer: clear cascade, open count gate, settle, latch BCD result.
// Optional macro FREQ_GATE_OVF_SAT_EN saturates the result to all-9 on overflow.
module freq_gate_ctrl
  import freq_gate_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CLR_CYCLES  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        cont,
  input  logic                        abort,
  input  logic [DIGIT_W*N_DIGITS-1:0] cnt_digits,
  input  logic                        cnt_carry_top,
  output logic                        cnt_clr,
  output logic                        cnt_en,
  output logic [DIGIT_W*N_DIGITS-1:0] result,
  output logic                        result_valid,
  output logic                        busy,
  output logic                        ovf
);

  localparam int unsigned RW   = DIGIT_W * N_DIGITS;
  localparam int unsigned TMAX = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_t          state, next_state;
  logic            ovf_acc;
  logic            timer_load, timer_en, timer_done;
  logic [TW-1:0]   timer_val;
  logic            clr_d, en_d, busy_d, latch;
  logic [RW-1:0]   latch_val;

  gate_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ovf_acc <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_CLEAR) begin
        ovf_acc <= 1'b0;
      end else if ((state == ST_GATE) && cnt_carry_top) begin
        ovf_acc <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_CLEAR;
      ST_CLEAR:  if (timer_done) next_state = ST_GATE;
      ST_GATE:   if (timer_done) next_state = ST_SETTLE;
      ST_SETTLE: next_state = ST_LATCH;
      ST_LATCH:  next_state = cont ? ST_CLEAR : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
    if (abort) next_state = ST_IDLE;
  end

  // Timer reloads only on entry, so it is never decremented past 1 inside a timed state.
  always_comb begin
    timer_load = ((next_state == ST_CLEAR) || (next_state == ST_GATE)) && (next_state != state);
    timer_val  = (next_state == ST_GATE) ? TW'(GATE_CYCLES) : TW'(CLR_CYCLES);
    timer_en   = !timer_load && ((state == ST_CLEAR) || (state == ST_GATE));
  end

  always_comb begin
    clr_d  = (next_state == ST_CLEAR);
    en_d   = (next_state == ST_GATE);
    busy_d = (next_state != ST_IDLE);
    latch  = (state == ST_LATCH) && !abort;
`ifdef FREQ_GATE_OVF_SAT_EN
    latch_val = ovf_acc ? RW'(all_nines(N_DIGITS)) : cnt_digits;
`else
    latch_val = cnt_digits;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_clr      <= 1'b0;
      cnt_en       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      ovf          <= 1'b0;
    end else begin
      cnt_clr      <= clr_d;
      cnt_en       <= en_d;
      busy         <= busy_d;
      result_valid <= latch;
      if (latch) begin
        result <= latch_val;
        ovf    <= ovf_acc;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl (GATE_CYCLES=8, CLR_CYCLES=2, N_DIGITS=4).
module tb_freq_gate_ctrl;

  localparam int GATE = 8;
  localparam int CLR  = 2;
  localparam int ND   = 4;
  localparam int P    = CLR + GATE + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, cont = 1'b0, abort = 1'b0, carry = 1'b0;
  logic [15:0] digits = '0;
  logic        cnt_clr, cnt_en, result_valid, busy, ovf;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;

  freq_gate_ctrl #(.N_DIGITS(ND), .GATE_CYCLES(GATE), .CLR_CYCLES(CLR)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cont          (cont),
    .abort         (abort),
    .cnt_digits    (digits),
    .cnt_carry_top (carry),
    .cnt_clr       (cnt_clr),
    .cnt_en        (cnt_en),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: position within a measurement (0 = idle, 1..P = cycle index).
  int          pos = 0;
  bit          m_acc = 0, m_valid = 0, m_ovf = 0;
  logic [15:0] m_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos = 0; m_acc = 0; m_valid = 0; m_ovf = 0; m_result = '0;
    end else begin
      m_valid = 0;
      if (abort) begin
        pos = 0;
      end else if (pos == 0) begin
        if (start) pos = 1;
      end else if (pos == P) begin
`ifdef FREQ_GATE_OVF_SAT_EN
        m_result = m_acc ? 16'h9999 : digits;
`else
        m_result = digits;
`endif
        m_ovf   = m_acc;
        m_valid = 1;
        pos     = cont ? 1 : 0;
      end else begin
        if (pos <= CLR) m_acc = 0;
        else if (pos <= CLR + GATE && carry) m_acc = 1;
        pos++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!result_valid && n < 40) begin
      tick();
      n++;
    end
    if (!result_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_en(input int count, input string name);
    int seen = 0;
    for (int i = 0; i < 40 && seen < count; i++) begin
      tick();
      if (cnt_en) seen++;
    end
    if (seen < count) check({name, "_en_timeout"}, seen, count);
  endtask

  typedef struct {
    logic        start;
    logic [15:0] digits;
    logic        clr, en, busy, valid, ovf;
    logic [15:0] result;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic c, logic e, logic b, logic v, logic [15:0] r);
    vec_t x;
    x.start = s; x.digits = 16'h0123; x.clr = c; x.en = e; x.busy = b; x.valid = v;
    x.ovf = 1'b0; x.result = r;
    return x;
  endfunction

  initial begin
    int n, t, nvalid;
    int vt[3];
    logic [15:0] prev;

    // Single shot: expected outputs after each clock edge.
    vecs.push_back(mk(1, 1, 0, 1, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 1, 0, 16'h0000));
    for (int i = 0; i < GATE; i++) vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0123));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0123));

    #3;
    check("reset_outputs", {cnt_clr, cnt_en, busy, result_valid, ovf, result}, '0);
    @(negedge clk); rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      start = vecs[i].start; digits = vecs[i].digits;
      tick();
      check($sformatf("single_%0d", i), {cnt_clr, cnt_en, busy, result_valid, ovf, result},
            {vecs[i].clr, vecs[i].en, vecs[i].busy, vecs[i].valid, vecs[i].ovf, vecs[i].result});
    end
    start = 0;

    // Continuous: three results 12 cycles apart, cont dropped in the third gate.
    digits = 16'h0456; cont = 1; start = 1;
    tick(); start = 0;
    nvalid = 0;
    for (t = 1; t <= 40; t++) begin
      tick();
      if (result_valid && nvalid < 3) begin vt[nvalid] = t; nvalid++; end
      if (t == 28) cont = 0;
      if (t == 36) check("cont_busy_after_third", busy, 0);
    end
    check("cont_count", nvalid, 3);
    check("cont_first", vt[0], P);
    check("cont_second", vt[1], 2 * P);
    check("cont_third", vt[2], 3 * P);
    check("cont_result", result, 16'h0456);

    // Abort on the 4th gate cycle.
    prev = result; digits = 16'h0777; start = 1;
    tick(); start = 0;
    wait_en(4, "abort");
    abort = 1;
    tick(); abort = 0;
    check("abort_outputs", {cnt_en, cnt_clr, busy, result_valid}, 0);
    check("abort_result", result, prev);
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n += result_valid; end
    check("abort_no_valid", n, 0);

    // Overflow mid-gate, then a clean measurement.
    digits = 16'h0042; start = 1;
    tick(); start = 0;
    wait_en(3, "ovf");
    carry = 1; tick(); carry = 0;
    wait_valid("ovf", n);
    check("ovf_flag", ovf, 1);
`ifdef FREQ_GATE_OVF_SAT_EN
    check("ovf_result", result, 16'h9999);
`else
    check("ovf_result", result, 16'h0042);
`endif
    tick();
    digits = 16'h0123; start = 1;
    tick(); start = 0;
    wait_valid("clean", n);
    check("clean_ovf", ovf, 0);
    check("clean_result", result, 16'h0123);
    tick();

    // Asynchronous reset mid-gate.
    start = 1; tick(); start = 0;
    wait_en(3, "rst");
    #2 rst = 1;
    #1 check("rst_async", {cnt_en, cnt_clr, busy, ovf, result}, 0);
    @(negedge clk); rst = 0;
    tick();
    start = 1; abort = 1;
    tick();
    check("start_abort_idle", {busy, cnt_clr}, 0);
    start = 0; abort = 0;
    tick();
    check("start_abort_stay", busy, 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 4) == 0;
      cont  = ($urandom % 3) != 0;
      abort = ($urandom % 40) == 0;
      carry = ($urandom % 30) == 0;
      for (int d = 0; d < ND; d++) digits[d*4 +: 4] = 4'($urandom % 10);
      tick();
      check($sformatf("rand_%0d", i), {cnt_clr, cnt_en, busy, result_valid, ovf, result},
            {pos >= 1 && pos <= CLR, pos > CLR && pos <= CLR + GATE, pos != 0,
             m_valid, m_ovf, m_result});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
